alu_input_sequencer: RTL and testbench
======================================

// Module: alu_input_sequencer
// PURPOSE
//   Front-end sequencer for the ALU/display datapath. Takes one raw push-button
//   and the slide switches. Debounces the button and steps an FSM through
//   operand A -> operand B -> opcode -> result.
//   Each step drives a shared data bus plus a one-cycle load strobe into the
//   downstream register_n instances (A, B, OP, RES).
// PARAMETERS
//   N           4  data width of sw/d_out; matches register_n width
//   DEB_CYCLES  4  consecutive stable synced samples before a level change is accepted; must be >= 4
// PORTS
//   clk       in   1  system clock; all state changes on posedge
//   rst       in   1  synchronous reset, active-high
//   btn       in   1  raw button, asynchronous, bouncy; 1 = pressed
//   sw        in   N  switch value to be loaded at the next step
//   d_out     out  N  data bus to the D inputs of the A/B/OP registers
//   load_a    out  1  one-cycle load strobe, operand A register
//   load_b    out  1  one-cycle load strobe, operand B register
//   load_op   out  1  one-cycle load strobe, opcode register
//   load_res  out  1  one-cycle load strobe, result register (captures ALU output)
//   phase     out  2  current FSM state code, for display/LEDs
// BEHAVIOUR
//   Reset (rst=1 at posedge):
//     - d_out=0; all load_* = 0; phase=0 (GET_A).
//     - Sync flops, debounce counter and accepted level all cleared to 0.
//     - Any in-progress debounce or pending press is discarded.
//   Synchroniser: 2-flop chain on btn -> bsync.
//   Debounce:
//     - cnt increments each cycle while bsync != level; cnt clears when they are equal.
//     - When cnt reaches DEB_CYCLES-1 while still differing: level <= bsync, cnt <= 0.
//   Press event: registered one-cycle pulse on the 0->1 transition of level. Releases (1->0) produce nothing.
//   Latency: btn stable high sampled first at edge t -> the matching load_* is high during cycle t+DEB_CYCLES+3.
//   Button held across reset release: counts as a press once debounced.
//   FSM states (phase code):
//     - GET_A=0, GET_B=1, GET_OP=2, SHOW=3.
//     - On press: d_out <= sw (sampled at the press cycle) and the state's strobe pulses for one cycle.
//   Transitions on press:
//     - GET_A:  load_a,  -> GET_B.
//     - GET_B:  load_b,  -> GET_OP.
//     - GET_OP: load_op, -> SHOW; load_res pulses the following cycle, so the ALU sees the new opcode first.
//     - SHOW:   load_a,  -> GET_B; starts a new operation with a fresh A, no return through GET_A.
//     - No press: state, d_out and strobes hold (strobes 0); d_out keeps the last loaded value.
//   Invariants:
//     - At most one load_* high in any cycle.
//     - load_res never coincides with a press, since DEB_CYCLES>=4 spaces presses >= 4 cycles apart.
//   Reset mid-operation: immediate return to GET_A; a load_res due next cycle is cancelled.
//   phase is a registered copy of the state and changes the same cycle the strobe is high.
// TESTING (N=4, DEB_CYCLES=4)
//   1. Hold rst 3 cycles, btn=0 -> d_out=0, all load_*=0, phase=0; stays idle 50 cycles.
//   2. sw=4'h5, btn clean high from edge t for 20 cycles
//      -> load_a=1 only in cycle t+7, d_out=5, phase=1.
//   3. btn toggles every 2 cycles for 12 cycles, then stable high -> exactly one load pulse;
//      no pulse during bounce; clean release gives no pulse.
//   4. Presses with sw=3,6,2 from GET_A -> load_a(d=3), load_b(d=6), load_op(d=2) one pulse each;
//      load_res exactly 1 cycle after load_op; phase 0->1->2->3.
//      Then press with sw=9 -> load_a, d_out=9, phase=1.
//   5. btn held high 200 cycles -> exactly one strobe; btn low then high again -> next strobe.
//   6a. rst during the load_op cycle -> no load_res follows; phase=0.
//   6b. Separately, rst while the debounce counter is mid-count -> that press is never emitted.

Source files
------------

// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer: debounces a raw push-button and steps the ALU operand
// entry sequence A -> B -> opcode -> result. Each accepted press puts the
// switch value on a shared data bus and pulses the load strobe of the
// register that owns the current step.
//
// Ports:
//   clk       system clock, all state changes on posedge
//   rst       synchronous reset, active-high
//   btn       raw asynchronous button, 1 = pressed
//   sw        switch value captured on a press
//   d_out     data bus to the A/B/OP register D inputs
//   load_a    one-cycle load strobe, operand A register
//   load_b    one-cycle load strobe, operand B register
//   load_op   one-cycle load strobe, opcode register
//   load_res  one-cycle load strobe, result register (cycle after load_op)
//   phase     current step code: 0=GET_A 1=GET_B 2=GET_OP 3=SHOW
module alu_input_sequencer #(
    parameter int unsigned N          = 4,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn,
    input  logic [N-1:0] sw,
    output logic [N-1:0] d_out,
    output logic         load_a,
    output logic         load_b,
    output logic         load_op,
    output logic         load_res,
    output logic [1:0]   phase
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        GET_A  = 2'd0,
        GET_B  = 2'd1,
        GET_OP = 2'd2,
        SHOW   = 2'd3
    } state_t;

    state_t        state;
    logic          sync1;
    logic          bsync;
    logic          level;
    logic          level_q;
    logic          press;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser, debounce counter and rising-edge press pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            bsync   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            bsync   <= sync1;
            level_q <= level;
            press   <= level & ~level_q;
            if (bsync != level) begin
                // Accept the new level only after it has differed for DEB_CYCLES samples.
                if (cnt == CNT_LAST) begin
                    level <= bsync;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Step FSM with registered bus and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= GET_A;
            d_out    <= '0;
            load_a   <= 1'b0;
            load_b   <= 1'b0;
            load_op  <= 1'b0;
            load_res <= 1'b0;
        end else begin
            load_a   <= 1'b0;
            load_b   <= 1'b0;
            load_op  <= 1'b0;
            // Result capture trails the opcode load so the ALU sees the new opcode first.
            load_res <= load_op;
            if (press) begin
                d_out <= sw;
                case (state)
                    GET_A: begin
                        load_a <= 1'b1;
                        state  <= GET_B;
                    end
                    GET_B: begin
                        load_b <= 1'b1;
                        state  <= GET_OP;
                    end
                    GET_OP: begin
                        load_op <= 1'b1;
                        state   <= SHOW;
                    end
                    SHOW: begin
                        // A new operation starts directly with a fresh A.
                        load_a <= 1'b1;
                        state  <= GET_B;
                    end
                endcase
            end
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Self-checking bench for alu_input_sequencer (N=4, DEB_CYCLES=4): directed
// vectors and sequences plus randomized button/switch/reset stimulus checked
// every cycle against a behavioural model.
module tb_alu_input_sequencer;

    localparam int unsigned N   = 4;
    localparam int unsigned DEB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn;
    logic [N-1:0] sw;
    logic [N-1:0] d_out;
    logic         load_a;
    logic         load_b;
    logic         load_op;
    logic         load_res;
    logic [1:0]   phase;

    always #5 clk = ~clk;

    alu_input_sequencer #(.N(N), .DEB_CYCLES(DEB)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .sw       (sw),
        .d_out    (d_out),
        .load_a   (load_a),
        .load_b   (load_b),
        .load_op  (load_op),
        .load_res (load_res),
        .phase    (phase)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Behavioural model: btn reaches the debouncer two edges late; the accepted
    // level flips after DEB consecutive differing samples; a rise acts on the
    // FSM two edges later; the result strobe trails the opcode strobe by one.
    int         m_d1, m_d2, m_level, m_streak, m_rise0, m_rise1, m_step;
    int         m_bs, m_act;
    logic [3:0] e_d;
    logic       e_a, e_b, e_op, e_res;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_d1 = 0; m_d2 = 0; m_level = 0; m_streak = 0;
            m_rise0 = 0; m_rise1 = 0; m_step = 0;
            e_d = '0; e_a = 0; e_b = 0; e_op = 0; e_res = 0;
        end else begin
            m_bs  = m_d2;
            m_d2  = m_d1;
            m_d1  = int'(btn);
            m_act = m_rise1;
            m_rise1 = m_rise0;
            e_res = e_op;
            e_a = 0; e_b = 0; e_op = 0;
            if (m_act != 0) begin
                e_d = sw;
                case (m_step)
                    0:       begin e_a  = 1; m_step = 1; end
                    1:       begin e_b  = 1; m_step = 2; end
                    2:       begin e_op = 1; m_step = 3; end
                    default: begin e_a  = 1; m_step = 1; end
                endcase
            end
            m_rise0 = 0;
            if (m_bs != m_level) begin
                m_streak++;
                if (m_streak == int'(DEB)) begin
                    m_level  = m_bs;
                    m_streak = 0;
                    m_rise0  = m_bs;
                end
            end else begin
                m_streak = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_d_out",    32'(d_out),    32'(e_d));
            chk("m_load_a",   32'(load_a),   32'(e_a));
            chk("m_load_b",   32'(load_b),   32'(e_b));
            chk("m_load_op",  32'(load_op),  32'(e_op));
            chk("m_load_res", 32'(load_res), 32'(e_res));
            chk("m_phase",    32'(phase),    32'(m_step));
            chk("m_onehot",   32'(int'(load_a) + int'(load_b) + int'(load_op) + int'(load_res) <= 1), 32'(1));
        end
    end

    // Run n cycles, counting cycles with an A/B/OP strobe high.
    task automatic run(input int n, output int s);
        s = 0;
        repeat (n) begin
            @(negedge clk);
            if (load_a | load_b | load_op) s++;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        btn = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // One clean press: returns the strobe cycle's outputs and load_res one cycle later.
    task automatic press(input logic [3:0] v, output bit found, output logic [6:0] obs, output logic res_next);
        int s;
        found = 0; obs = '0; res_next = 1'b0;
        @(negedge clk);
        sw  = v;
        btn = 1'b1;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (load_a | load_b | load_op) begin
                found = 1;
                obs = {load_a, load_b, load_op, phase, d_out[1:0]};
                chk("press_d_out", 32'(d_out), 32'(v));
            end
        end
        @(negedge clk);
        res_next = load_res;
        btn = 1'b0;
        run(15, s);
    endtask

    typedef struct {
        logic [3:0] sw;
        logic       ea;
        logic       eb;
        logic       eop;
        logic [1:0] eph;
        logic       eres;
    } vec_t;

    initial begin
        vec_t       vt[4];
        bit         found;
        logic [6:0] obs;
        logic       rn;
        int         s, pos, cnt, run_left;

        vt[0] = '{4'h3, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0};
        vt[1] = '{4'h6, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0};
        vt[2] = '{4'h2, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1};
        vt[3] = '{4'h9, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0};

        // Reset state and idle.
        rst = 1'b1; btn = 1'b0; sw = '0;
        repeat (3) @(negedge clk);
        chk("rst_d_out", 32'(d_out), 32'(0));
        chk("rst_loads", 32'({load_a, load_b, load_op, load_res}), 32'(0));
        chk("rst_phase", 32'(phase), 32'(0));
        rst = 1'b0;
        chk_en = 1'b1;
        run(50, s);
        chk("idle_strobes", 32'(s), 32'(0));
        chk("idle_phase", 32'(phase), 32'(0));

        // Clean press: load_a exactly DEB+3 cycles after the first high sample.
        @(negedge clk);
        sw = 4'h5; btn = 1'b1;
        pos = -1; cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (load_a | load_b | load_op) begin
                cnt++;
                if (pos < 0) begin
                    pos = k;
                    chk("t2_load_a", 32'(load_a), 32'(1));
                    chk("t2_d_out", 32'(d_out), 32'(5));
                    chk("t2_phase", 32'(phase), 32'(1));
                end
            end
        end
        chk("t2_latency", 32'(pos), 32'(DEB + 3));
        chk("t2_count", 32'(cnt), 32'(1));
        btn = 1'b0;
        run(20, s);
        chk("t2_release", 32'(s), 32'(0));

        // Bouncing button: nothing until it settles, then one strobe.
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            btn = ~btn;
            run(2, s);
            cnt += s;
        end
        chk("t3_bounce", 32'(cnt), 32'(0));
        btn = 1'b1;
        run(20, s);
        chk("t3_settled", 32'(s), 32'(1));
        btn = 1'b0;
        run(20, s);
        chk("t3_release", 32'(s), 32'(0));

        // Full operation table from GET_A, then a new A from SHOW.
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            press(vt[i].sw, found, obs, rn);
            chk("t4_found", 32'(found), 32'(1));
            chk("t4_strobes", 32'(obs[6:4]), 32'({vt[i].ea, vt[i].eb, vt[i].eop}));
            chk("t4_phase", 32'(obs[3:2]), 32'(vt[i].eph));
            chk("t4_res_next", 32'(rn), 32'(vt[i].eres));
        end

        // Long hold gives one strobe; re-press gives the next.
        btn = 1'b1;
        run(200, s);
        chk("t5_hold", 32'(s), 32'(1));
        btn = 1'b0;
        run(10, s);
        btn = 1'b1;
        run(20, s);
        chk("t5_repress", 32'(s), 32'(1));
        btn = 1'b0;
        run(15, s);

        // Reset during the load_op cycle cancels load_res.
        do_reset(2);
        press(4'h3, found, obs, rn);
        press(4'h6, found, obs, rn);
        @(negedge clk);
        sw = 4'h2; btn = 1'b1;
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (load_op) found = 1;
        end
        chk("t6a_found", 32'(found), 32'(1));
        rst = 1'b1; btn = 1'b0;
        @(negedge clk);
        chk("t6a_no_res", 32'(load_res), 32'(0));
        chk("t6a_phase", 32'(phase), 32'(0));
        rst = 1'b0;
        run(5, s);
        chk("t6a_after", 32'(s | int'(load_res)), 32'(0));

        // Reset mid-debounce discards the pending press.
        @(negedge clk);
        btn = 1'b1;
        run(3, s);
        rst = 1'b1; btn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run(20, s);
        chk("t6b_discard", 32'(s), 32'(0));
        chk("t6b_phase", 32'(phase), 32'(0));

        // Randomized stimulus against the model.
        run_left = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (run_left == 0) begin
                btn      = 1'($urandom_range(0, 1));
                run_left = int'($urandom_range(1, 12));
            end
            run_left--;
            sw  = 4'($urandom);
            rst = ($urandom_range(0, 399) == 0);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
